// File: rtl/leg_mem_pkg.sv
// Shared types and default widths for the fetch/execute memory interface.
package leg_mem_pkg;

  localparam int unsigned LEG_DATA_WIDTH = 8;
  localparam int unsigned LEG_ADDR_WIDTH = 12;
  localparam int unsigned LEG_INST_BYTES = 4;
  localparam int unsigned LEG_INST_WIDTH = LEG_INST_BYTES * LEG_DATA_WIDTH;
  localparam int unsigned LEG_WAIT_WIDTH = 4;

  typedef enum logic [1:0] {
    MR_IDLE  = 2'd0,
    MR_WAIT  = 2'd1,
    MR_BURST = 2'd2,
    MR_WRITE = 2'd3
  } mr_state_e;

  // Access state a request proceeds to once any wait states have elapsed.
  function automatic mr_state_e mr_access_state(input logic is_write);
    return is_write ? MR_WRITE : MR_BURST;
  endfunction

endpackage

// File: rtl/byte_ram.sv
// Byte-wide single-port RAM: synchronous write, asynchronous read.
module byte_ram #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter string       INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Single write port.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: word-burst reads and byte writes over a req/ack handshake.
module mem_responder
  import leg_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = LEG_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH  = LEG_ADDR_WIDTH,
  parameter int unsigned INST_BYTES  = LEG_INST_BYTES,
  parameter int unsigned INST_WIDTH  = INST_BYTES * DATA_WIDTH,
  parameter int unsigned WAIT_STATES = 0,
  parameter string       INIT_FILE   = ""
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_flush,
  input  logic                  i_req,
  input  logic                  i_write,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic                  o_busy,
  output logic                  o_ack,
  output logic [INST_WIDTH-1:0] o_rdata
);

  localparam int unsigned BYTE_CNT_W = (INST_BYTES > 1) ? $clog2(INST_BYTES) : 1;
  localparam int unsigned WAIT_CNT_W = LEG_WAIT_WIDTH;
  localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(INST_BYTES - 1);
  localparam logic [WAIT_CNT_W-1:0] LAST_WAIT =
    WAIT_CNT_W'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

  mr_state_e             state;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic [BYTE_CNT_W-1:0] byte_cnt;
  logic [INST_WIDTH-1:0] shadow;
  logic [INST_WIDTH-1:0] shadow_next;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  ram_we;

  // Burst address wraps naturally modulo 2**ADDR_WIDTH; writes use offset 0.
  assign ram_addr    = base_addr + ADDR_WIDTH'(byte_cnt);
  // A reset or flush in the write cycle must leave the RAM untouched.
  assign ram_we      = (state == MR_WRITE) && !i_rst && !i_flush;
  // Earlier bytes move toward the MSB as each new byte arrives.
  assign shadow_next = (shadow << DATA_WIDTH) | INST_WIDTH'(ram_rdata);

  byte_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .INIT_FILE  (INIT_FILE)
  ) u_ram (
    .clk   (i_clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  // Request FSM with wait/byte counters, shadow assembly and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= MR_IDLE;
      o_busy    <= 1'b0;
      o_ack     <= 1'b0;
      o_rdata   <= '0;
      shadow    <= '0;
      wait_cnt  <= '0;
      byte_cnt  <= '0;
      base_addr <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
    end else begin
      o_ack <= 1'b0;
      if (i_flush) begin
        // Abort anything in flight; a request seen with flush is dropped.
        state    <= MR_IDLE;
        o_busy   <= 1'b0;
        wait_cnt <= '0;
        byte_cnt <= '0;
      end else begin
        case (state)
          MR_IDLE: begin
            if (i_req) begin
              base_addr <= i_addr;
              write_q   <= i_write;
              wdata_q   <= i_wdata;
              wait_cnt  <= '0;
              byte_cnt  <= '0;
              o_busy    <= 1'b1;
              state     <= (WAIT_STATES != 0) ? MR_WAIT : mr_access_state(i_write);
            end
          end
          MR_WAIT: begin
            if (wait_cnt == LAST_WAIT) begin
              wait_cnt <= '0;
              state    <= mr_access_state(write_q);
            end else begin
              wait_cnt <= wait_cnt + WAIT_CNT_W'(1);
            end
          end
          MR_BURST: begin
            shadow <= shadow_next;
            if (byte_cnt == LAST_BYTE) begin
              o_rdata  <= shadow_next;
              o_ack    <= 1'b1;
              o_busy   <= 1'b0;
              byte_cnt <= '0;
              state    <= MR_IDLE;
            end else begin
              byte_cnt <= byte_cnt + BYTE_CNT_W'(1);
            end
          end
          MR_WRITE: begin
            o_ack  <= 1'b1;
            o_busy <= 1'b0;
            state  <= MR_IDLE;
          end
          default: begin
            o_busy <= 1'b0;
            state  <= MR_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Randomised self-checking bench for mem_responder (WAIT_STATES = 0 and 3 instances).
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst, flush, req, write, cur;
  logic [11:0] addr;
  logic [7:0]  wdata;
  logic        req0, req3, busy0, busy3, ack0, ack3;
  logic [31:0] rdata0, rdata3;
  logic        busy_m, ack_m;
  logic [31:0] rdata_m;

  int checks = 0;
  int failures = 0;

  logic [7:0]  m0 [4096];
  logic [7:0]  m3 [4096];
  logic [31:0] last_rd0, last_rd3;

  always #5 clk = ~clk;

  assign req0    = req & ~cur;
  assign req3    = req & cur;
  assign busy_m  = cur ? busy3 : busy0;
  assign ack_m   = cur ? ack3 : ack0;
  assign rdata_m = cur ? rdata3 : rdata0;

  mem_responder #(.WAIT_STATES(0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_req(req0), .i_write(write),
    .i_addr(addr), .i_wdata(wdata), .o_busy(busy0), .o_ack(ack0), .o_rdata(rdata0));

  mem_responder #(.WAIT_STATES(3)) dut3 (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_req(req3), .i_write(write),
    .i_addr(addr), .i_wdata(wdata), .o_busy(busy3), .o_ack(ack3), .o_rdata(rdata3));

  // Reference: word = bytes at a, a+1, ... packed MSB-first, addresses modulo 4096.
  function automatic logic [31:0] exp_word(input logic sel, input logic [11:0] a);
    logic [31:0] w;
    logic [11:0] p;
    w = '0;
    for (int k = 0; k < 4; k++) begin
      p = a + 12'(k);
      w = {w[23:0], (sel ? m3[p] : m0[p])};
    end
    return w;
  endfunction

  function automatic int exp_lat(input logic sel, input logic wr);
    return (sel ? 3 : 0) + (wr ? 1 : 4);
  endfunction

  task automatic model_write(input logic sel, input logic [11:0] a, input logic [7:0] d);
    if (sel) m3[a] = d; else m0[a] = d;
  endtask

  // Issue one request; report edges from accept to ack, busy cycles, data, busy in ack cycle.
  task automatic run_op(input logic sel, input logic wr, input logic [11:0] a,
                        input logic [7:0] d, input bit hold, output int lat,
                        output int busy_cyc, output logic [31:0] rd,
                        output logic busy_at_ack, output bit to);
    @(negedge clk);
    cur = sel; write = wr; addr = a; wdata = d; req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    busy_cyc = busy_m ? 1 : 0;
    if (!hold) req = 1'b0;
    lat = 0; to = 1'b1; rd = '0; busy_at_ack = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (ack_m) begin
        to = 1'b0; rd = rdata_m; busy_at_ack = busy_m;
        break;
      end
      if (busy_m) busy_cyc++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; flush = 1'b0; req = 1'b0; write = 1'b0; cur = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL reset_busy0 got=%b exp=0", busy0); end
    checks++; if (ack0 !== 1'b0) begin failures++; $display("FAIL reset_ack0 got=%b exp=0", ack0); end
    checks++; if (rdata0 !== 32'h0) begin failures++; $display("FAIL reset_rdata0 got=%h exp=0", rdata0); end
    checks++; if (busy3 !== 1'b0) begin failures++; $display("FAIL reset_busy3 got=%b exp=0", busy3); end
    checks++; if (ack3 !== 1'b0) begin failures++; $display("FAIL reset_ack3 got=%b exp=0", ack3); end
    checks++; if (rdata3 !== 32'h0) begin failures++; $display("FAIL reset_rdata3 got=%h exp=0", rdata3); end
    rst = 1'b0;
    last_rd0 = '0; last_rd3 = '0;
  endtask

  // Fill FF8..00F on both instances so every word read there is known.
  task automatic preload;
    int l, b; logic [31:0] r; logic ba; bit to; logic [7:0] d;
    for (int s = 0; s < 2; s++) begin
      for (int o = 0; o < 24; o++) begin
        d = 8'($urandom);
        run_op(1'(s), 1'b1, 12'hFF8 + 12'(o), d, 1'b0, l, b, r, ba, to);
        model_write(1'(s), 12'hFF8 + 12'(o), d);
      end
    end
  endtask

  task automatic write_bytes(input logic sel, input logic [11:0] a, input logic [31:0] v);
    int l, b; logic [31:0] r; logic ba; bit to; logic [7:0] d;
    for (int k = 0; k < 4; k++) begin
      d = v[31 - 8*k -: 8];
      run_op(sel, 1'b1, a + 12'(k), d, 1'b0, l, b, r, ba, to);
      model_write(sel, a + 12'(k), d);
    end
  endtask

  task automatic test_read_basic;
    int l, b; logic [31:0] r; logic ba; bit to;
    write_bytes(1'b0, 12'h000, 32'hF1420000);
    run_op(1'b0, 1'b0, 12'h000, 8'h00, 1'b0, l, b, r, ba, to);
    checks++; if (to || l != 4) begin failures++; $display("FAIL read_latency got=%0d exp=4 timeout=%0b", l, to); end
    checks++; if (r !== 32'hF1420000) begin failures++; $display("FAIL read_data got=%h exp=F1420000", r); end
    checks++; if (ba !== 1'b0) begin failures++; $display("FAIL read_busy_in_ack got=%b exp=0", ba); end
    last_rd0 = 32'hF1420000;
  endtask

  task automatic test_write;
    int l, b; logic [31:0] r; logic ba; bit to;
    write_bytes(1'b0, 12'h004, 32'hF0880000);
    run_op(1'b0, 1'b1, 12'h005, 8'hAB, 1'b0, l, b, r, ba, to);
    model_write(1'b0, 12'h005, 8'hAB);
    checks++; if (to || l != 1) begin failures++; $display("FAIL write_latency got=%0d exp=1 timeout=%0b", l, to); end
    checks++; if (r !== last_rd0) begin failures++; $display("FAIL write_keeps_rdata got=%h exp=%h", r, last_rd0); end
    run_op(1'b0, 1'b0, 12'h004, 8'h00, 1'b0, l, b, r, ba, to);
    checks++; if (to || r !== 32'hF0AB0000) begin failures++; $display("FAIL write_readback got=%h exp=F0AB0000", r); end
    last_rd0 = 32'hF0AB0000;
  endtask

  task automatic test_wrap;
    int l, b; logic [31:0] r; logic ba; bit to;
    run_op(1'b0, 1'b1, 12'hFFE, 8'h11, 1'b0, l, b, r, ba, to); model_write(1'b0, 12'hFFE, 8'h11);
    run_op(1'b0, 1'b1, 12'hFFF, 8'h22, 1'b0, l, b, r, ba, to); model_write(1'b0, 12'hFFF, 8'h22);
    run_op(1'b0, 1'b0, 12'hFFE, 8'h00, 1'b0, l, b, r, ba, to);
    checks++; if (to || r !== 32'h1122F142) begin failures++; $display("FAIL wrap_read got=%h exp=1122F142", r); end
    last_rd0 = 32'h1122F142;
  endtask

  task automatic test_wait_hold;
    int l, b, l2; logic [31:0] r, e1, e2; logic ba; bit to, got;
    write_bytes(1'b1, 12'h000, 32'hF1420000);
    e1 = exp_word(1'b1, 12'h000);
    e2 = exp_word(1'b1, 12'h004);
    run_op(1'b1, 1'b0, 12'h000, 8'h00, 1'b1, l, b, r, ba, to);
    checks++; if (to || l != 7) begin failures++; $display("FAIL wait_latency got=%0d exp=7 timeout=%0b", l, to); end
    checks++; if (b != 7) begin failures++; $display("FAIL wait_busy_cycles got=%0d exp=7", b); end
    checks++; if (r !== e1) begin failures++; $display("FAIL wait_read_data got=%h exp=%h", r, e1); end
    checks++; if (ba !== 1'b0) begin failures++; $display("FAIL wait_busy_in_ack got=%b exp=0", ba); end
    // i_req is still high: next edge must accept the new address.
    addr = 12'h004;
    @(posedge clk);
    @(negedge clk);
    checks++; if (busy_m !== 1'b1) begin failures++; $display("FAIL hold_accept busy got=%b exp=1", busy_m); end
    req = 1'b0;
    l2 = 0; got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); l2++; @(negedge clk);
      if (ack_m) begin got = 1'b1; r = rdata_m; break; end
    end
    checks++; if (!got || l2 != 7) begin failures++; $display("FAIL hold_latency got=%0d exp=7 acked=%0b", l2, got); end
    checks++; if (r !== e2) begin failures++; $display("FAIL hold_read_data got=%h exp=%h", r, e2); end
    last_rd3 = e2;
  endtask

  task automatic test_flush;
    int l, b; logic [31:0] r, e; logic ba; bit to, saw;
    // Flush a read in its second burst cycle.
    @(negedge clk); cur = 1'b0; write = 1'b0; addr = 12'h004; req = 1'b1;
    @(posedge clk); @(negedge clk); req = 1'b0;
    @(posedge clk); @(negedge clk); flush = 1'b1;
    @(posedge clk); @(negedge clk); flush = 1'b0;
    checks++; if (busy0 !== 1'b0 || ack0 !== 1'b0) begin failures++; $display("FAIL flush_read_idle busy=%b ack=%b exp=0/0", busy0, ack0); end
    checks++; if (rdata0 !== last_rd0) begin failures++; $display("FAIL flush_read_rdata got=%h exp=%h", rdata0, last_rd0); end
    saw = 1'b0;
    repeat (6) begin @(negedge clk); if (ack0) saw = 1'b1; end
    checks++; if (saw !== 1'b0) begin failures++; $display("FAIL flush_read_no_ack got=%b exp=0", saw); end
    e = exp_word(1'b0, 12'hFFE);
    run_op(1'b0, 1'b0, 12'hFFE, 8'h00, 1'b0, l, b, r, ba, to);
    checks++; if (to || r !== e) begin failures++; $display("FAIL flush_then_read got=%h exp=%h", r, e); end
    last_rd0 = e;
    // Flush a write while it is still waiting; RAM must not change.
    @(negedge clk); cur = 1'b1; write = 1'b1; addr = 12'h009; wdata = ~m3[12'h009]; req = 1'b1;
    @(posedge clk); @(negedge clk); req = 1'b0; flush = 1'b1;
    @(posedge clk); @(negedge clk); flush = 1'b0;
    checks++; if (busy3 !== 1'b0) begin failures++; $display("FAIL flush_write_idle busy got=%b exp=0", busy3); end
    e = exp_word(1'b1, 12'h009);
    run_op(1'b1, 1'b0, 12'h009, 8'h00, 1'b0, l, b, r, ba, to);
    checks++; if (to || r !== e) begin failures++; $display("FAIL flush_write_ram got=%h exp=%h", r, e); end
    last_rd3 = e;
    // Flush while idle swallows a concurrent request.
    @(negedge clk); cur = 1'b0; write = 1'b0; addr = 12'h000; req = 1'b1; flush = 1'b1;
    @(posedge clk); @(negedge clk); req = 1'b0; flush = 1'b0;
    checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL flush_idle_req busy got=%b exp=0", busy0); end
  endtask

  task automatic test_random;
    int l, b; logic [31:0] r, e; logic ba; bit to; logic wr; logic [11:0] a; logic [7:0] d;
    for (int s = 0; s < 2; s++) begin
      for (int n = 0; n < 25; n++) begin
        wr = ($urandom_range(0, 2) == 0);
        a  = 12'hFF8 + 12'($urandom_range(0, 15));
        d  = 8'($urandom);
        e  = wr ? (s == 1 ? last_rd3 : last_rd0) : exp_word(1'(s), a);
        run_op(1'(s), wr, a, d, 1'b0, l, b, r, ba, to);
        if (wr) model_write(1'(s), a, d);
        else if (s == 1) last_rd3 = e;
        else last_rd0 = e;
        checks++;
        if (to || l != exp_lat(1'(s), wr) || r !== e || ba !== 1'b0) begin
          failures++;
          $display("FAIL rand_op inst=%0d wr=%0b addr=%h lat=%0d exp_lat=%0d data=%h exp=%h busy_ack=%b",
                   s, wr, a, l, exp_lat(1'(s), wr), r, e, ba);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    int l, b; logic [31:0] r, e; logic ba; bit to, saw;
    @(negedge clk); cur = 1'b1; write = 1'b1; addr = 12'h009; wdata = ~m3[12'h009]; req = 1'b1;
    @(posedge clk); @(negedge clk); req = 1'b0; rst = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++; if (busy3 !== 1'b0 || ack3 !== 1'b0 || rdata3 !== 32'h0) begin
      failures++; $display("FAIL reset_mid_outputs busy=%b ack=%b rdata=%h exp=0/0/0", busy3, ack3, rdata3);
    end
    saw = 1'b0;
    repeat (2) begin @(negedge clk); if (ack3) saw = 1'b1; end
    rst = 1'b0;
    repeat (6) begin @(negedge clk); if (ack3 || busy3) saw = 1'b1; end
    checks++; if (saw !== 1'b0) begin failures++; $display("FAIL reset_mid_no_ack got=%b exp=0", saw); end
    e = exp_word(1'b1, 12'h009);
    run_op(1'b1, 1'b0, 12'h009, 8'h00, 1'b0, l, b, r, ba, to);
    checks++; if (to || r !== e) begin failures++; $display("FAIL reset_mid_ram got=%h exp=%h", r, e); end
  endtask

  initial begin
    test_reset();
    preload();
    test_read_basic();
    test_write();
    test_wrap();
    test_wait_hold();
    test_flush();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
